// File: rtl/red_pitaya_na_sweep_block_pkg.sv
// Shared definitions for the network-analyzer sweep block: register map,
// status bit layout and sweep FSM encoding.
package red_pitaya_na_sweep_block_pkg;

    localparam logic [15:0] ADDR_CTRL   = 16'h000;
    localparam logic [15:0] ADDR_START  = 16'h004;
    localparam logic [15:0] ADDR_STEP   = 16'h008;
    localparam logic [15:0] ADDR_POINTS = 16'h00C;
    localparam logic [15:0] ADDR_STATUS = 16'h010;
    localparam logic [15:0] ADDR_I_LO   = 16'h014;
    localparam logic [15:0] ADDR_I_HI   = 16'h018;
    localparam logic [15:0] ADDR_Q_LO   = 16'h01C;
    localparam logic [15:0] ADDR_Q_HI   = 16'h020;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    localparam int ST_DONE_BIT  = 31;
    localparam int ST_RUN_BIT   = 30;
    localparam int ST_FULL_BIT  = 29;
    localparam int ST_EMPTY_BIT = 28;
    localparam int ST_COUNT_LSB = 16;
    localparam int ST_COUNT_W   = 12;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_STORE = 3'd4
    } sweep_state_t;

    function automatic logic [31:0] pack_status(
        input logic        done,
        input logic        running,
        input logic        full,
        input logic        empty,
        input logic [11:0] count,
        input logic [15:0] pts
    );
        logic [31:0] s;
        s                            = '0;
        s[ST_DONE_BIT]               = done;
        s[ST_RUN_BIT]                = running;
        s[ST_FULL_BIT]               = full;
        s[ST_EMPTY_BIT]              = empty;
        s[ST_COUNT_LSB +: ST_COUNT_W] = count;
        s[15:0]                      = pts;
        return s;
    endfunction

endpackage

// File: rtl/red_pitaya_na_fifo.sv
// Synchronous show-ahead result FIFO; head_o always presents the oldest entry.
module red_pitaya_na_fifo #(
    parameter int WIDTH = 124,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o  = (count_q == (AW+1)'(DEPTH));
        empty_o = (count_q == '0);
        // clear takes priority over any coincident push or pop
        push_ok = push_i && !full_o && !clear_i;
        pop_ok  = pop_i && !empty_o && !clear_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
            else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/red_pitaya_na_sweep_block.sv
// Network-analyzer frequency sweep: steps the IQ block through a list of
// frequencies, waits for each average and queues the quadrature results.
//
// state   | meaning
// IDLE    | no sweep; waits for start
// STEP    | pulse freq_we_o so the IQ block loads freq_o
// ARM     | guard cycle while avg_busy_i rises
// WAIT    | averaging in progress
// STORE   | push result, advance frequency (stalls while FIFO full)
module red_pitaya_na_sweep_block
    import red_pitaya_na_sweep_block_pkg::*;
#(
    parameter int PHASEBITS = 32,
    parameter int SUMBITS   = 62,
    parameter int FIFOAW    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [PHASEBITS-1:0] freq_o,
    output logic                 freq_we_o,
    input  logic                 avg_busy_i,
    input  logic [SUMBITS-1:0]   i_sum_i,
    input  logic [SUMBITS-1:0]   q_sum_i,
    input  logic [15:0]          addr,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [31:0]          wdata,
    output logic                 ack,
    output logic [31:0]          rdata
);

    sweep_state_t           state_q, state_d;
    logic [PHASEBITS-1:0]   freq_q, freq_d;
    logic [PHASEBITS-1:0]   start_freq_q, start_freq_d;
    logic [PHASEBITS-1:0]   step_q, step_d;
    logic [31:0]            points_q, points_d;
    logic [31:0]            points_done_q, points_done_d;
    logic                   done_q, done_d;
    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;

    logic                   ctrl_wr, start_cmd, abort_cmd, clear_cmd;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFOAW:0]        fifo_count;
    logic [2*SUMBITS-1:0]   fifo_head, head;
    logic [SUMBITS-1:0]     head_i, head_q;
    logic [63:0]            i_ext, q_ext;
    logic [31:0]            rd_val;

    always_comb begin
        ctrl_wr   = wen && (addr == ADDR_CTRL);
        start_cmd = ctrl_wr && wdata[CTRL_START_BIT];
        abort_cmd = ctrl_wr && wdata[CTRL_ABORT_BIT];
        clear_cmd = ctrl_wr && wdata[CTRL_CLEAR_BIT];
        fifo_pop  = ren && (addr == ADDR_Q_HI) && !fifo_empty;

        start_freq_d = start_freq_q;
        step_d       = step_q;
        points_d     = points_q;
        if (wen && addr == ADDR_START)  start_freq_d = wdata[PHASEBITS-1:0];
        if (wen && addr == ADDR_STEP)   step_d       = wdata[PHASEBITS-1:0];
        if (wen && addr == ADDR_POINTS) points_d     = wdata;
    end

    always_comb begin
        state_d       = state_q;
        freq_d        = freq_q;
        points_done_d = points_done_q;
        done_d        = done_q;
        fifo_push     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    if (points_q != '0) begin
                        freq_d        = start_freq_q;
                        points_done_d = '0;
                        done_d        = 1'b0;
                        state_d       = S_STEP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_STEP:  state_d = S_ARM;
            S_ARM:   state_d = S_WAIT;
            S_WAIT:  if (!avg_busy_i) state_d = S_STORE;
            S_STORE: begin
                if (!fifo_full) begin
                    fifo_push     = 1'b1;
                    points_done_d = points_done_q + 1'b1;
                    freq_d        = freq_q + step_q;
                    if (points_done_d == points_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort freezes everything except the state itself
        if (abort_cmd) begin
            state_d       = S_IDLE;
            freq_d        = freq_q;
            points_done_d = points_done_q;
            done_d        = done_q;
            fifo_push     = 1'b0;
        end
    end

    red_pitaya_na_fifo #(
        .WIDTH (2*SUMBITS),
        .AW    (FIFOAW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_cmd),
        .push_i      (fifo_push),
        .push_data_i ({i_sum_i, q_sum_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        head   = fifo_empty ? '0 : fifo_head;
        head_i = head[2*SUMBITS-1:SUMBITS];
        head_q = head[SUMBITS-1:0];
        i_ext  = {{(64-SUMBITS){head_i[SUMBITS-1]}}, head_i};
        q_ext  = {{(64-SUMBITS){head_q[SUMBITS-1]}}, head_q};

        case (addr)
            ADDR_START:  rd_val = 32'(start_freq_q);
            ADDR_STEP:   rd_val = 32'(step_q);
            ADDR_POINTS: rd_val = points_q;
            ADDR_STATUS: rd_val = pack_status(done_q, state_q != S_IDLE,
                                              fifo_full, fifo_empty,
                                              12'(fifo_count),
                                              points_done_q[15:0]);
            ADDR_I_LO:   rd_val = i_ext[31:0];
            ADDR_I_HI:   rd_val = i_ext[63:32];
            ADDR_Q_LO:   rd_val = q_ext[31:0];
            ADDR_Q_HI:   rd_val = q_ext[63:32];
            default:     rd_val = '0;
        endcase

        ack_d   = wen | ren;
        rdata_d = ren ? rd_val : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            freq_q        <= '0;
            start_freq_q  <= '0;
            step_q        <= '0;
            points_q      <= '0;
            points_done_q <= '0;
            done_q        <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            freq_q        <= freq_d;
            start_freq_q  <= start_freq_d;
            step_q        <= step_d;
            points_q      <= points_d;
            points_done_q <= points_done_d;
            done_q        <= done_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
        end
    end

    assign freq_o    = freq_q;
    assign freq_we_o = (state_q == S_STEP);
    assign ack       = ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_red_pitaya_na_sweep_block.sv
// Bench for the sweep block: register vectors, directed sweep scenarios and
// randomized sweeps against a queue-based model of the expected results.
module tb_red_pitaya_na_sweep_block;
    import red_pitaya_na_sweep_block_pkg::*;

    localparam int PB  = 32;
    localparam int SB  = 62;
    localparam int FAW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [PB-1:0] freq_o;
    logic          freq_we_o;
    logic          avg_busy_i = 1'b0;
    logic [SB-1:0] i_sum_i = '0;
    logic [SB-1:0] q_sum_i = '0;
    logic [15:0]   addr = '0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [31:0]   wdata = '0;
    logic          ack;
    logic [31:0]   rdata;

    always #5 clk_i = ~clk_i;

    red_pitaya_na_sweep_block #(.PHASEBITS(PB), .SUMBITS(SB), .FIFOAW(FAW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .freq_o     (freq_o),
        .freq_we_o  (freq_we_o),
        .avg_busy_i (avg_busy_i),
        .i_sum_i    (i_sum_i),
        .q_sum_i    (q_sum_i),
        .addr       (addr),
        .wen        (wen),
        .ren        (ren),
        .wdata      (wdata),
        .ack        (ack),
        .rdata      (rdata)
    );

    int checks = 0;
    int errors = 0;

    // IQ-block model: busy rises one cycle after each freq_we_o and stays
    // high busy_len cycles; a fresh random sum pair appears as busy rises.
    int          busy_len = 5;
    int          busy_cnt = 0;
    bit          pend = 0;
    bit          force_neg5 = 0;
    int          pulse_cnt = 0;
    int unsigned pulse_freq[$];
    longint      gen_i[$];
    longint      gen_q[$];
    longint      m_vi, m_vq;

    always begin
        @(posedge clk_i);
        #2;
        if (rst_i) begin
            avg_busy_i = 1'b0;
            pend       = 0;
            busy_cnt   = 0;
        end else begin
            if (avg_busy_i) begin
                if (busy_cnt <= 1) avg_busy_i = 1'b0;
                else busy_cnt--;
            end
            if (pend) begin
                m_vi = longint'({$urandom(), $urandom()}) >>> (64 - SB);
                m_vq = longint'({$urandom(), $urandom()}) >>> (64 - SB);
                if (force_neg5) begin
                    m_vi       = -5;
                    force_neg5 = 0;
                end
                i_sum_i    = m_vi[SB-1:0];
                q_sum_i    = m_vq[SB-1:0];
                gen_i.push_back(m_vi);
                gen_q.push_back(m_vq);
                avg_busy_i = 1'b1;
                busy_cnt   = busy_len;
                pend       = 0;
            end
            if (freq_we_o) begin
                pend = 1;
                pulse_cnt++;
                pulse_freq.push_back(freq_o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        tick(1);
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        addr = a;
        ren  = 1'b1;
        tick(1);
        ren  = 1'b0;
        d    = rdata;
        chk("ack", 64'(ack), 64'd1);
    endtask

    task automatic clear_model();
        pulse_cnt = 0;
        pulse_freq.delete();
        gen_i.delete();
        gen_q.delete();
    endtask

    task automatic start_sweep(input logic [31:0] f0, input logic [31:0] st,
                               input logic [31:0] n, input int len);
        clear_model();
        busy_len = len;
        bus_write(ADDR_START, f0);
        bus_write(ADDR_STEP, st);
        bus_write(ADDR_POINTS, n);
        bus_write(ADDR_CTRL, 32'h1);
    endtask

    task automatic wait_done(input int max_reads);
        logic [31:0] s;
        bit          ok;
        ok = 0;
        for (int k = 0; k < max_reads && !ok; k++) begin
            bus_read(ADDR_STATUS, s);
            if (s[31] && !s[30]) ok = 1;
        end
        chk("wait_done", 64'(ok), 64'd1);
    endtask

    task automatic wait_pulses(input int n, input int max_cycles);
        int k;
        k = 0;
        while (pulse_cnt < n && k < max_cycles) begin
            tick(1);
            k++;
        end
        chk("wait_pulses", 64'(pulse_cnt >= n), 64'd1);
    endtask

    task automatic check_freqs(input int unsigned f0, input int unsigned st, input int n);
        int unsigned e;
        chk("pulse_count", 64'(pulse_cnt), 64'(n));
        for (int k = 0; k < n && k < pulse_freq.size(); k++) begin
            e = f0 + st * k;
            chk($sformatf("freq[%0d]", k), 64'(pulse_freq[k]), 64'(e));
        end
    endtask

    task automatic read_entry(input int idx);
        logic [31:0] d;
        logic [63:0] ui, uq;
        if (idx >= gen_i.size()) begin
            chk($sformatf("entry%0d_exists", idx), 64'd0, 64'd1);
        end else begin
            ui = gen_i[idx];
            uq = gen_q[idx];
            bus_read(ADDR_I_LO, d); chk($sformatf("e%0d_i_lo", idx), 64'(d), 64'(ui[31:0]));
            bus_read(ADDR_I_HI, d); chk($sformatf("e%0d_i_hi", idx), 64'(d), 64'(ui[63:32]));
            bus_read(ADDR_Q_LO, d); chk($sformatf("e%0d_q_lo", idx), 64'(d), 64'(uq[31:0]));
            bus_read(ADDR_Q_HI, d); chk($sformatf("e%0d_q_hi", idx), 64'(d), 64'(uq[63:32]));
        end
    endtask

    function automatic logic [31:0] status_word(input bit done, input bit run, input bit full,
                                                input bit empty, input int cnt, input int pd);
        return (32'(done) << 31) | (32'(run) << 30) | (32'(full) << 29) |
               (32'(empty) << 28) | (32'(cnt) << 16) | 32'(pd & 16'hFFFF);
    endfunction

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[13];
        logic [31:0] d;
        logic [31:0] n, f0, st;
        int          len;

        vecs[0]  = '{1'b0, ADDR_STATUS, 32'h0,         32'h1000_0000};
        vecs[1]  = '{1'b1, ADDR_START,  32'h1234_5678, 32'h0};
        vecs[2]  = '{1'b0, ADDR_START,  32'h0,         32'h1234_5678};
        vecs[3]  = '{1'b1, ADDR_STEP,   32'h0000_ABCD, 32'h0};
        vecs[4]  = '{1'b0, ADDR_STEP,   32'h0,         32'h0000_ABCD};
        vecs[5]  = '{1'b1, ADDR_POINTS, 32'h0000_0007, 32'h0};
        vecs[6]  = '{1'b0, ADDR_POINTS, 32'h0,         32'h0000_0007};
        vecs[7]  = '{1'b0, ADDR_CTRL,   32'h0,         32'h0};
        vecs[8]  = '{1'b0, 16'h0024,    32'h0,         32'h0};
        vecs[9]  = '{1'b0, 16'h0100,    32'h0,         32'h0};
        vecs[10] = '{1'b0, ADDR_I_LO,   32'h0,         32'h0};
        vecs[11] = '{1'b0, ADDR_Q_HI,   32'h0,         32'h0};
        vecs[12] = '{1'b0, ADDR_STATUS, 32'h0,         32'h1000_0000};

        // reset values
        tick(3);
        chk("rst_freq_o", 64'(freq_o), 64'd0);
        chk("rst_freq_we", 64'(freq_we_o), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        rst_i = 1'b0;
        tick(1);

        // register map vectors
        for (int k = 0; k < 13; k++) begin
            if (vecs[k].wr) begin
                bus_write(vecs[k].a, vecs[k].d);
            end else begin
                bus_read(vecs[k].a, d);
                chk($sformatf("vec%0d", k), 64'(d), 64'(vecs[k].exp));
            end
        end

        // zero points: done immediately, no pulse
        clear_model();
        bus_write(ADDR_POINTS, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_STATUS, d);
        chk("zero_pts_status", 64'(d), 64'(status_word(1, 0, 0, 1, 0, 0)));
        tick(10);
        chk("zero_pts_pulses", 64'(pulse_cnt), 64'd0);

        // basic 3-point sweep, with a second start while running
        start_sweep(1000, 10, 3, 5);
        bus_write(ADDR_CTRL, 32'h1);
        wait_done(200);
        check_freqs(1000, 10, 3);
        bus_read(ADDR_STATUS, d);
        chk("sweep3_status", 64'(d), 64'(status_word(1, 0, 0, 0, 3, 3)));
        for (int k = 0; k < 3; k++) read_entry(k);
        bus_read(ADDR_STATUS, d);
        chk("sweep3_drained", 64'(d), 64'(status_word(1, 0, 0, 1, 0, 3)));

        // 20 points into a 16-deep FIFO: stall, then drain to finish
        start_sweep(5, 3, 20, 2);
        begin
            bit full_seen;
            full_seen = 0;
            for (int k = 0; k < 300 && !full_seen; k++) begin
                bus_read(ADDR_STATUS, d);
                if (d[29]) full_seen = 1;
            end
            chk("full_reached", 64'(full_seen), 64'd1);
        end
        tick(20);
        bus_read(ADDR_STATUS, d);
        chk("stall_status", 64'(d), 64'(status_word(0, 1, 1, 0, 16, 16)));
        chk("stall_pulses", 64'(pulse_cnt), 64'd17);
        for (int k = 0; k < 4; k++) read_entry(k);
        wait_done(200);
        bus_read(ADDR_STATUS, d);
        chk("sweep20_status", 64'(d), 64'(status_word(1, 0, 1, 0, 16, 20)));
        check_freqs(5, 3, 20);
        for (int k = 4; k < 20; k++) read_entry(k);
        bus_read(ADDR_STATUS, d);
        chk("sweep20_drained", 64'(d), 64'(status_word(1, 0, 0, 1, 0, 20)));

        // phase word wraps modulo 2^32, then fifo_clear
        start_sweep(32'hFFFF_FFF0, 32'h20, 2, 3);
        wait_done(200);
        check_freqs(32'hFFFF_FFF0, 32'h20, 2);
        if (pulse_freq.size() > 1) chk("wrap_freq", 64'(pulse_freq[1]), 64'h10);
        bus_write(ADDR_CTRL, 32'h4);
        bus_read(ADDR_STATUS, d);
        chk("clear_status", 64'(d), 64'(status_word(1, 0, 0, 1, 0, 2)));

        // abort during WAIT of the second point
        force_neg5 = 1;
        start_sweep(100, 7, 5, 10);
        wait_pulses(2, 400);
        tick(3);
        bus_write(ADDR_CTRL, 32'h2);
        bus_read(ADDR_STATUS, d);
        chk("abort_status", 64'(d), 64'(status_word(0, 0, 0, 0, 1, 1)));
        tick(30);
        chk("abort_pulses", 64'(pulse_cnt), 64'd2);
        chk("abort_freq_held", 64'(freq_o), 64'd107);
        bus_read(ADDR_I_LO, d);
        chk("neg5_i_lo", 64'(d), 64'hFFFF_FFFB);
        bus_read(ADDR_I_HI, d);
        chk("neg5_i_hi", 64'(d), 64'hFFFF_FFFF);
        read_entry(0);

        // reset in WAIT abandons the sweep
        start_sweep(200, 1, 3, 10);
        wait_pulses(1, 100);
        tick(3);
        rst_i = 1'b1;
        tick(1);
        chk("mid_rst_freq_o", 64'(freq_o), 64'd0);
        chk("mid_rst_freq_we", 64'(freq_we_o), 64'd0);
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_rdata", 64'(rdata), 64'd0);
        rst_i = 1'b0;
        tick(1);
        bus_read(ADDR_STATUS, d);
        chk("mid_rst_status", 64'(d), 64'h1000_0000);
        bus_read(ADDR_START, d);
        chk("mid_rst_start_reg", 64'(d), 64'd0);
        tick(30);
        chk("mid_rst_pulses", 64'(pulse_cnt), 64'd1);

        // randomized sweeps
        for (int r = 0; r < 4; r++) begin
            f0  = $urandom();
            st  = $urandom();
            n   = 32'($urandom_range(1, 6));
            len = int'($urandom_range(1, 6));
            start_sweep(f0, st, n, len);
            wait_done(300);
            check_freqs(f0, st, int'(n));
            bus_read(ADDR_STATUS, d);
            chk($sformatf("rand%0d_status", r), 64'(d),
                64'(status_word(1, 0, 0, 0, int'(n), int'(n))));
            for (int k = 0; k < int'(n); k++) read_entry(k);
            bus_read(ADDR_STATUS, d);
            chk($sformatf("rand%0d_drained", r), 64'(d),
                64'(status_word(1, 0, 0, 1, 0, int'(n))));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/red_pitaya_na_sweep_block.md
RED_PITAYA_NA_SWEEP_BLOCK -- requirements
Module: red_pitaya_na_sweep_block

Interface
REQ-001 SHALL have parameter PHASEBITS, default 32, width of the frequency (phase increment) word.
REQ-002 SHALL have parameter SUMBITS, default 62, width of each averaged quadrature sum.
REQ-003 SHALL have parameter FIFOAW, default 4, log2 of result FIFO depth (16 entries).
REQ-004 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous reset, active high.
REQ-005 SHALL have freq_o  out  PHASEBITS  frequency word driven to the IQ block phase-shift register.
REQ-006 SHALL have freq_we_o  out  1  one-cycle strobe; the IQ block loads freq_o and restarts averaging.
REQ-007 SHALL have avg_busy_i  in  1  IQ block averaging in progress, registered there, rises 1 cycle after freq_we_o.
REQ-008 SHALL have i_sum_i, q_sum_i  in  SUMBITS each  signed averaged quadrature sums, valid while avg_busy_i=0.
REQ-009 SHALL have addr in 16, wen in 1, ren in 1, wdata in 32, ack out 1 (registered), rdata out 32 (registered).

Function
REQ-010 Registers: 0x000 ctrl (W: bit0 start, bit1 abort, bit2 fifo_clear; R: 0); 0x004 start_freq; 0x008 step_freq; 0x00C points (32b); 0x010 status {done[31], running[30], full[29], empty[28], fifo_count[27:16], points_done[15:0]}.
REQ-011 Head entry read-only: 0x014 i[31:0]; 0x018 i[SUMBITS-1:32] sign-extended; 0x01C q[31:0]; 0x020 q[SUMBITS-1:32] sign-extended; an ren at 0x020 with FIFO non-empty pops one entry.
REQ-012 ack SHALL equal wen|ren registered one cycle; rdata updates the same cycle; unmapped addresses read 0.
REQ-013 FSM states IDLE, STEP, ARM, WAIT, STORE; reset state IDLE.
REQ-014 IDLE: start with points!=0 loads freq_o<=start_freq, clears points_done and done, goes STEP; start with points=0 sets done, stays IDLE.
REQ-015 STEP: freq_we_o=1 for exactly this cycle, go ARM; ARM: one guard cycle, go WAIT.
REQ-016 WAIT: remain while avg_busy_i=1; on avg_busy_i=0 go STORE.
REQ-017 STORE: if FIFO not full, push {i_sum_i,q_sum_i}, increment points_done, freq_o<=freq_o+step_freq (modulo 2^PHASEBITS); if points_done+1==points set done and go IDLE, else go STEP; if FIFO full, stall in STORE with no push.
REQ-018 running SHALL be 1 in every state except IDLE.
REQ-019 start while running SHALL be ignored.
REQ-020 abort SHALL return FSM to IDLE next cycle from any state, done unchanged, FIFO contents kept, freq_o held.
REQ-021 fifo_clear SHALL empty the FIFO next cycle; if coincident with push, clear wins.
REQ-022 Simultaneous push and pop SHALL both occur, fifo_count unchanged; pop on empty SHALL be ignored and read zeros.
REQ-023 points_done SHALL report the low 16 bits of its 32-bit counter.

Reset
REQ-024 rst_i SHALL set: FSM IDLE, freq_o=0, freq_we_o=0, ack=0, rdata=0, all config registers 0, done=0, points_done=0, FIFO empty.
REQ-025 rst_i mid-sweep SHALL abandon the sweep with no further freq_we_o pulse.

Structure
REQ-026 Register offsets, status bit positions and FSM state encodings SHALL live in a shared package/include.
REQ-027 The FIFO SHALL be sub-module red_pitaya_na_fifo (synchronous, width 2*SUMBITS, depth 2^FIFOAW, count/full/empty outputs, show-ahead head).

Verification
REQ-028 start_freq=1000, step=10, points=3, busy model 5 cycles -> three freq_we_o pulses with freq_o 1000,1010,1020; 3 FIFO entries; done=1; running=0.
REQ-029 points=0, start -> no freq_we_o, done=1 next cycle, FIFO empty.
REQ-030 points=20, no reads -> 16 entries stored, full=1, FSM stalls in STORE; four pops -> sweep completes with points_done=20.
REQ-031 start_freq=0xFFFFFFF0, step=0x20, points=2 -> second freq_o=0x00000010.
REQ-032 abort during WAIT -> IDLE next cycle, no further freq_we_o, stored entries intact; i_sum_i=-5 reads 0x018 as 0xFFFFFFFF.
REQ-033 rst_i asserted in WAIT -> all outputs at reset values next cycle, status reads 0x10000000.
